// File: rtl/da_fir_pkg.sv
// Shared widths, state encoding and helpers for the distributed-arithmetic FIR.
// Build option: DA_TWOS_COMP_EN makes the top plane subtract (signed samples).
package da_fir_pkg;

  localparam int NUM_ROMS = 8;
  localparam int ROM_AW   = 8;
  localparam int ROM_DEPTH = 1 << ROM_AW;
  localparam int COEF_W   = 20;
  localparam int SUM_W    = 23;
  localparam int ACC_W    = 38;
  localparam int NBITS    = 8;
  localparam int KW       = $clog2(NBITS);
  localparam int SEL_W    = $clog2(NUM_ROMS);
  localparam int CADDR_W  = SEL_W + ROM_AW;

  localparam logic [KW-1:0] K_FIRST = '0;
  localparam logic [KW-1:0] K_LAST  = KW'(NBITS - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  function automatic logic signed [SUM_W-1:0] coef_ext(
    input logic signed [COEF_W-1:0] c
  );
    return {{(SUM_W-COEF_W){c[COEF_W-1]}}, c};
  endfunction

  function automatic logic signed [ACC_W-1:0] sum_ext(
    input logic signed [SUM_W-1:0] s
  );
    return {{(ACC_W-SUM_W){s[SUM_W-1]}}, s};
  endfunction

endpackage

// File: rtl/da_fir_if.sv
// Bundle of the FIR's data, coefficient-load and result signals.
// master drives requests and coefficients; slave is the filter.
interface da_fir_if;
  import da_fir_pkg::*;

  logic [ROM_AW-1:0]        A0;
  logic [ROM_AW-1:0]        A1;
  logic [ROM_AW-1:0]        A2;
  logic [ROM_AW-1:0]        A3;
  logic [ROM_AW-1:0]        A4;
  logic [ROM_AW-1:0]        A5;
  logic [ROM_AW-1:0]        A6;
  logic [ROM_AW-1:0]        A7;
  logic signed [COEF_W-1:0] CIN;
  logic [CADDR_W-1:0]       CADDR;
  logic                     CLOAD;
  logic                     valid_in;
  logic                     start;
  logic signed [ACC_W-1:0]  ACC_OUT;
  logic                     valid_out;

  modport master (
    output A0, A1, A2, A3, A4, A5, A6, A7,
    output CIN, CADDR, CLOAD, valid_in, start,
    input  ACC_OUT, valid_out
  );

  modport slave (
    input  A0, A1, A2, A3, A4, A5, A6, A7,
    input  CIN, CADDR, CLOAD, valid_in, start,
    output ACC_OUT, valid_out
  );

endinterface

// File: rtl/da_rom.sv
// 256 x 20 coefficient table: one synchronous write port, combinational read.
// Contents are deliberately not reset, so they survive resetn.
module da_rom
  import da_fir_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [ROM_AW-1:0]        waddr_i,
  input  logic signed [COEF_W-1:0] wdata_i,
  input  logic [ROM_AW-1:0]        raddr_i,
  output logic signed [COEF_W-1:0] rdata_o
);

  logic signed [COEF_W-1:0] mem_q [ROM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Same-cycle read of a word being written sees the old value.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/da_fir.sv
// Bit-serial distributed-arithmetic FIR: one bit plane per cycle, 8 cycles/result.
// Build option: DA_TWOS_COMP_EN subtracts plane 7 for two's-complement samples.
module da_fir
  import da_fir_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  da_fir_if.slave bus
);

  logic [ROM_AW-1:0]        raddr [NUM_ROMS];
  logic signed [COEF_W-1:0] rdata [NUM_ROMS];
  logic                     wr_en;
  logic [SEL_W-1:0]         wr_sel;
  logic [ROM_AW-1:0]        wr_addr;

  state_e                   state_q;
  logic [KW-1:0]            k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  out_q;
  logic                     vld_q;

  logic signed [SUM_W-1:0]  sum_d;
  logic signed [ACC_W-1:0]  term_d;
  logic signed [ACC_W-1:0]  base_d;

  assign raddr[0] = bus.A0;
  assign raddr[1] = bus.A1;
  assign raddr[2] = bus.A2;
  assign raddr[3] = bus.A3;
  assign raddr[4] = bus.A4;
  assign raddr[5] = bus.A5;
  assign raddr[6] = bus.A6;
  assign raddr[7] = bus.A7;

  assign wr_en   = bus.CLOAD & bus.valid_in;
  assign wr_sel  = bus.CADDR[CADDR_W-1:ROM_AW];
  assign wr_addr = bus.CADDR[ROM_AW-1:0];

  for (genvar j = 0; j < NUM_ROMS; j++) begin : g_rom
    logic we;
    assign we = wr_en && (wr_sel == SEL_W'(j));

    da_rom u_rom (
      .clk_i   (clk),
      .we_i    (we),
      .waddr_i (wr_addr),
      .wdata_i (bus.CIN),
      .raddr_i (raddr[j]),
      .rdata_o (rdata[j])
    );
  end

  always_comb begin
    sum_d = '0;
    for (int j = 0; j < NUM_ROMS; j++) begin
      sum_d = sum_d + coef_ext(rdata[j]);
    end
  end

  // Plane k carries weight 2^k; k=0 restarts the accumulation.
  assign term_d = sum_ext(sum_d) <<< k_q;
  assign base_d = (k_q == K_FIRST) ? '0 : acc_q;

`ifdef DA_TWOS_COMP_EN
  assign acc_d = (k_q == K_LAST) ? (base_d - term_d)
                                 : (base_d + term_d);
`else
  assign acc_d = base_d + term_d;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            k_q     <= '0;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          k_q   <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            out_q <= acc_d;
            vld_q <= 1'b1;
            // start high here chains straight into the next k=0.
            if (!bus.start) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ACC_OUT   = out_q;
  assign bus.valid_out = vld_q;

endmodule

// File: tb/tb_da_fir.sv
// Directed bench for da_fir: ROM load, plane patterns, chaining, reset, start drop.
`timescale 1ns/1ps
module tb_da_fir;
  import da_fir_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   passed = 0;
  int   total  = 0;

  da_fir_if bus ();

  da_fir dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

`ifdef DA_TWOS_COMP_EN
  localparam logic signed [37:0] EXP_FF = -38'sd2040;
`else
  localparam logic signed [37:0] EXP_FF = 38'sd520200;
`endif

  task automatic chk(input string tag,
                     input logic signed [37:0] got,
                     input logic signed [37:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] paddr(input int mode, input int k,
                                       input int j);
    case (mode)
      0: return 8'hFF;
      1: return (k == 3 && j == 3) ? 8'h10 : 8'h00;
      3: return (j == 0 && k < 2) ? 8'h05 : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic set_planes(input int mode, input int k);
    bus.A0 = paddr(mode, k, 0);
    bus.A1 = paddr(mode, k, 1);
    bus.A2 = paddr(mode, k, 2);
    bus.A3 = paddr(mode, k, 3);
    bus.A4 = paddr(mode, k, 4);
    bus.A5 = paddr(mode, k, 5);
    bus.A6 = paddr(mode, k, 6);
    bus.A7 = paddr(mode, k, 7);
  endtask

  task automatic wr(input int addr, input int data, input logic v);
    bus.CADDR    = 11'(addr);
    bus.CIN      = 20'(data);
    bus.CLOAD    = 1'b1;
    bus.valid_in = v;
    step();
    bus.CLOAD    = 1'b0;
    bus.valid_in = 1'b0;
  endtask

  // One conversion from IDLE; mode 3 also writes ROM0[5] during k=0.
  task automatic conv(input int mode, input int drop_k,
                      input logic signed [37:0] exp, input string tag);
    bus.start = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      set_planes(mode, k);
      if (mode == 3 && k == 0) begin
        bus.CADDR    = 11'd5;
        bus.CIN      = 20'sd1000;
        bus.CLOAD    = 1'b1;
        bus.valid_in = 1'b1;
      end
      if (k == 1) begin
        bus.CLOAD    = 1'b0;
        bus.valid_in = 1'b0;
      end
      if (k == drop_k || k == 7) bus.start = 1'b0;
      step();
    end
    chk({tag, "_vld"}, 38'(bus.valid_out), 38'sd1);
    chk({tag, "_acc"}, bus.ACC_OUT, exp);
    set_planes(2, 0);
    step();
    chk({tag, "_vld_drop"}, 38'(bus.valid_out), 38'sd0);
  endtask

  initial begin
    int pulses;
    int seen [$];
    resetn       = 1'b0;
    bus.start    = 1'b0;
    bus.CLOAD    = 1'b0;
    bus.valid_in = 1'b0;
    bus.CADDR    = '0;
    bus.CIN      = '0;
    set_planes(2, 0);
    step();
    step();
    chk("rst_acc", bus.ACC_OUT, 38'sd0);
    chk("rst_vld", 38'(bus.valid_out), 38'sd0);
    resetn = 1'b1;
    step();

    for (int a = 0; a < 2048; a++) wr(a, a & 255, 1'b1);

    conv(0, 99, EXP_FF, "all_ff");
    conv(1, 99, 38'sd128, "plane3");
    conv(2, 99, 38'sd0, "zeros");

    wr(0, 999, 1'b0);
    conv(2, 99, 38'sd0, "ign_wr");

    conv(3, 99, 38'sd2005, "wr_rd_same");
    wr(5, 5, 1'b1);

    // Held start: back-to-back conversions, one pulse every 8 cycles.
    bus.start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (bus.valid_out === 1'b1) seen.push_back(c);
    end
    chk("chain_cnt", 38'(seen.size()), 38'sd4);
    for (int n = 0; n < seen.size(); n++)
      chk("chain_pos", 38'(seen[n]), 38'(9 + 8 * n));
    bus.start = 1'b0;
    step();
    step();
    step();

    // Reset mid-conversion clears outputs at once and discards the run.
    conv(0, 99, EXP_FF, "pre_rst");
    bus.start = 1'b1;
    step();
    set_planes(0, 0);
    for (int k = 0; k < 4; k++) step();
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_k4_acc", bus.ACC_OUT, 38'sd0);
    chk("rst_k4_vld", 38'(bus.valid_out), 38'sd0);
    bus.start = 1'b0;
    step();
    resetn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.valid_out !== 1'b0) pulses++;
    end
    chk("rst_no_pulse", 38'(pulses), 38'sd0);
    chk("rst_hold_acc", bus.ACC_OUT, 38'sd0);
    conv(0, 99, EXP_FF, "post_rst");

    // start dropped at k=2 still completes, then the FSM idles.
    conv(0, 2, EXP_FF, "drop_k2");
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.valid_out !== 1'b0) pulses++;
    end
    chk("drop_idle", 38'(pulses), 38'sd0);
    chk("drop_hold", bus.ACC_OUT, EXP_FF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/da_fir.md
DA_FIR -- requirements
Module: da_fir

Interface
REQ-001 Parameters: none; all widths come from package constants.
REQ-002 There SHALL be one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 A0..A7  input  8 each  bit-plane address for coefficient ROM 0..7; one plane per compute cycle.
REQ-006 CIN  input  20 signed  coefficient write data.
REQ-007 CADDR  input  11  write address; [10:8] selects ROM, [7:0] selects entry.
REQ-008 CLOAD  input  1  coefficient write request.
REQ-009 valid_in  input  1  qualifies CLOAD.
REQ-010 start  input  1  level request to run conversions.
REQ-011 ACC_OUT  output  38 signed  filter result, held between results.
REQ-012 valid_out  output  1  one-cycle pulse when ACC_OUT updates.

Function
REQ-013 Storage: 8 ROMs, 256 x 20-bit signed each (2048 words total), plus a write port; read is combinational.
REQ-014 Write: when CLOAD=1 and valid_in=1 at a rising edge, ROM[CADDR[10:8]][CADDR[7:0]] <= CIN; CLOAD=1 with valid_in=0 is ignored.
REQ-015 A write and a read of the same word in one cycle returns the old value; the new value is visible the next cycle.
REQ-016 Writes are permitted in any FSM state.
REQ-017 FSM states: IDLE and RUN, with a 3-bit bit counter k.
REQ-018 In IDLE with start=1, the FSM moves to RUN with k=0 at the next edge.
REQ-019 start is sampled only in IDLE and at k=7.
REQ-020 Per RUN cycle: S_k = sum over j=0..7 of ROMj[Aj], with 23-bit signed width.
REQ-021 Accumulator update: acc <= (k==0 ? 0 : acc) + (S_k << k).
REQ-022 At k=7: ACC_OUT <= final acc and valid_out=1 in the following cycle only.
REQ-023 At k=7 with start=1, the next cycle is k=0 of a new conversion (throughput: one result per 8 cycles); with start=0, the FSM returns to IDLE.
REQ-024 Deasserting start mid-conversion does not abort; the conversion completes.
REQ-025 Arithmetic: sign-extend to 38 bits; no overflow is possible (|result| < 2^31); no saturation.
REQ-026 ACC_OUT holds its last value until the next completion; valid_out=0 otherwise.

Reset
REQ-027 resetn=0 forces IDLE, k=0, acc=0, ACC_OUT=0 and valid_out=0 immediately.
REQ-028 A conversion in progress during reset is discarded.
REQ-029 ROM contents are not cleared by reset; reading an unwritten word yields X.

Configuration
REQ-030 Macro DA_TWOS_COMP_EN defined: the k=7 plane is subtracted (acc - (S_7 << 7)), giving two's-complement samples.
REQ-031 Macro DA_TWOS_COMP_EN undefined: all planes are added, giving unsigned samples.

Structure
REQ-032 Package da_fir_pkg holds NUM_ROMS=8, ROM_AW=8, COEF_W=20, SUM_W=23, ACC_W=38, NBITS=8 and the state enum {IDLE, RUN}.
REQ-033 One sub-module, da_rom, implements a 256x20 single-write/async-read array, instantiated 8 times.

Verification
REQ-034 Load ROMj[a]=a for all j,a (2048 writes via CLOAD/valid_in); start=1; all A=8'hFF for 8 cycles -> ACC_OUT=520200 with one valid_out pulse (DA_TWOS_COMP_EN: -2040).
REQ-035 Same ROMs; only plane 3 has A3=8'h10, all other A=0 -> ACC_OUT=128.
REQ-036 All planes A=0 -> ACC_OUT=0; start held high -> valid_out pulses every 8 cycles.
REQ-037 CLOAD=1 with valid_in=0 writing CIN=999 to address 0 -> plane 0 with A0=0 still yields 0.
REQ-038 Assert resetn=0 at k=4 -> ACC_OUT=0 and valid_out=0 immediately; no pulse until a fresh conversion completes.
REQ-039 Drop start at k=2 -> the conversion still completes with one valid_out pulse, then the FSM returns to IDLE.
